// File: rtl/unidade_controle_pkg.sv
//==============================================================================
// Module      : unidade_controle_pkg
// Description : Shared opcodes, ALU encodings, FSM states and op classes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package unidade_controle_pkg;

    localparam logic [3:0] c_OP_NOP = 4'h0;
    localparam logic [3:0] c_OP_MOV = 4'h1;
    localparam logic [3:0] c_OP_LDI = 4'h2;
    localparam logic [3:0] c_OP_ADD = 4'h3;
    localparam logic [3:0] c_OP_SUB = 4'h4;

    localparam logic [1:0] c_ULA_PASSA    = 2'b00;
    localparam logic [1:0] c_ULA_SOMA     = 2'b01;
    localparam logic [1:0] c_ULA_SUBTRAI  = 2'b10;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        DECODIFICA = 3'd1,
        FASE1      = 3'd2,
        FASE2      = 3'd3,
        FIM        = 3'd4
    } estado_t;

    typedef enum logic [2:0] {
        CL_NOP    = 3'd0,
        CL_MOV    = 3'd1,
        CL_LDI    = 3'd2,
        CL_ADD    = 3'd3,
        CL_SUB    = 3'd4,
        CL_ILEGAL = 3'd7
    } classe_t;

    function automatic logic [3:0] um_quente(input logic [1:0] reg_idx);
        return 4'b0001 << reg_idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/unidade_controle_decodificador.sv
//==============================================================================
// Module      : decodificador_instr
// Description : Maps an opcode to legality, phase count and operation class.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module decodificador_instr
    import unidade_controle_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       legal,
    output logic       two_phase,
    output classe_t    classe
);

    always_comb begin
        legal     = 1'b1;
        two_phase = 1'b0;
        classe    = CL_ILEGAL;
        case (opcode)
            c_OP_NOP: classe = CL_NOP;
            c_OP_MOV: classe = CL_MOV;
            c_OP_LDI: classe = CL_LDI;
            c_OP_ADD: begin
                classe    = CL_ADD;
                two_phase = 1'b1;
            end
            c_OP_SUB: begin
                classe    = CL_SUB;
                two_phase = 1'b1;
            end
            default:  legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/unidade_controle.sv
//==============================================================================
// Module      : unidade_controle
// Description : Multi-cycle control unit for a 4-register datapath with ACC.
//               Optional retired-instruction counter: CONTADOR_INSTR_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module unidade_controle
    import unidade_controle_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] instrucao,
    input  logic        valido,
    output logic        aceito,
    output logic [1:0]  M,
    output logic [3:0]  carrega,
    output logic        carrega_acc,
    output logic        sel_imediato,
    output logic [15:0] imediato,
    output logic [1:0]  ula_op,
    output logic        concluido,
    output logic        erro
`ifdef CONTADOR_INSTR_EN
    ,
    output logic [15:0] num_instr
`endif
);

    estado_t     r_estado;
    logic [15:0] r_instr;

    logic        w_legal;
    logic        w_dois_fases;
    classe_t     w_classe;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;

    logic [1:0]  w_f2_m;
    logic [3:0]  w_f2_carrega;
    logic        w_f2_sel;
    logic [1:0]  w_f2_ula;

    assign w_rd     = r_instr[11:10];
    assign w_rs     = r_instr[9:8];
    assign imediato = {8'h00, r_instr[7:0]};

    decodificador_instr u_decod (
        .opcode    (r_instr[15:12]),
        .legal     (w_legal),
        .two_phase (w_dois_fases),
        .classe    (w_classe)
    );

    // Output values to be registered on entry to FASE2.
    always_comb begin
        w_f2_m       = 2'b00;
        w_f2_carrega = 4'b0000;
        w_f2_sel     = 1'b0;
        w_f2_ula     = c_ULA_PASSA;
        case (w_classe)
            CL_MOV: begin
                w_f2_m       = w_rs;
                w_f2_carrega = um_quente(w_rd);
            end
            CL_LDI: begin
                w_f2_sel     = 1'b1;
                w_f2_carrega = um_quente(w_rd);
            end
            CL_ADD: begin
                w_f2_m       = w_rs;
                w_f2_ula     = c_ULA_SOMA;
                w_f2_carrega = um_quente(w_rd);
            end
            CL_SUB: begin
                w_f2_m       = w_rs;
                w_f2_ula     = c_ULA_SUBTRAI;
                w_f2_carrega = um_quente(w_rd);
            end
            default: ;
        endcase
    end

    // Outputs are registered with the value of the state being entered.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_estado     <= OCIOSO;
            r_instr      <= 16'h0000;
            aceito       <= 1'b1;
            M            <= 2'b00;
            carrega      <= 4'b0000;
            carrega_acc  <= 1'b0;
            sel_imediato <= 1'b0;
            ula_op       <= c_ULA_PASSA;
            concluido    <= 1'b0;
            erro         <= 1'b0;
`ifdef CONTADOR_INSTR_EN
            num_instr    <= 16'h0000;
`endif
        end else begin
            aceito       <= 1'b0;
            M            <= 2'b00;
            carrega      <= 4'b0000;
            carrega_acc  <= 1'b0;
            sel_imediato <= 1'b0;
            ula_op       <= c_ULA_PASSA;
            concluido    <= 1'b0;
            erro         <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (valido && aceito) begin
                        r_instr  <= instrucao;
                        r_estado <= DECODIFICA;
                    end else begin
                        aceito   <= 1'b1;
                    end
                end
                DECODIFICA: begin
                    if (!w_legal) begin
                        r_estado <= FIM;
                        erro     <= 1'b1;
                    end else if (w_dois_fases) begin
                        r_estado    <= FASE1;
                        M           <= w_rd;
                        carrega_acc <= 1'b1;
                    end else begin
                        r_estado     <= FASE2;
                        M            <= w_f2_m;
                        carrega      <= w_f2_carrega;
                        sel_imediato <= w_f2_sel;
                        ula_op       <= w_f2_ula;
                    end
                end
                FASE1: begin
                    r_estado     <= FASE2;
                    M            <= w_f2_m;
                    carrega      <= w_f2_carrega;
                    sel_imediato <= w_f2_sel;
                    ula_op       <= w_f2_ula;
                end
                FASE2: begin
                    r_estado  <= FIM;
                    concluido <= 1'b1;
`ifdef CONTADOR_INSTR_EN
                    num_instr <= num_instr + 16'd1;
`endif
                end
                FIM: begin
                    r_estado <= OCIOSO;
                    aceito   <= 1'b1;
                end
                default: begin
                    r_estado <= OCIOSO;
                    aceito   <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
